// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Synchronous byte FIFO on the UART transmit path. The host pushes bytes and
// the transmitter pops them. Storage is a register array addressed by
// wrap-around read and write pointers. An occupancy counter drives the
// empty, full and level outputs.
//
// Handshake semantics:
//   A push is accepted when host_wr_en is high and FIFO_ctrl_full is low at a
//   rising edge of glb_clk. A pop is accepted when UART_ctrl_FIFO_r_en is high
//   and FIFO_ctrl_empty is low at a rising edge. The popped byte appears on
//   FIFO_rd_data after that edge and holds until the next accepted pop. A
//   request that is not accepted has no effect on storage, pointers or data.
//
// Optional feature:
//   `UART_FIFO_ERR_FLAGS_EN builds the sticky overflow and underflow flags,
//   which are cleared by host_err_clr. When it is not defined, both flags are
//   tied to 0 and host_err_clr is ignored.
//
// Ports:
//   glb_clk              system clock; rising edge
//   glb_rst              synchronous active-high reset
//   host_wr_en           push request
//   host_wr_data         byte to push
//   UART_ctrl_FIFO_r_en  pop request from the transmitter
//   FIFO_rd_data         popped byte (registered)
//   FIFO_ctrl_empty      occupancy == 0
//   FIFO_ctrl_full       occupancy == DEPTH
//   FIFO_level           occupancy, 0..DEPTH
//   host_err_clr         clears the sticky flags
//   FIFO_overflow        sticky: push attempted while full
//   FIFO_underflow       sticky: pop attempted while empty
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              glb_clk,
  input  logic              glb_rst,
  input  logic              host_wr_en,
  input  logic [DATA_W-1:0] host_wr_data,
  input  logic              UART_ctrl_FIFO_r_en,
  output logic [DATA_W-1:0] FIFO_rd_data,
  output logic              FIFO_ctrl_empty,
  output logic              FIFO_ctrl_full,
  output logic [ADDR_W:0]   FIFO_level,
  input  logic              host_err_clr,
  output logic              FIFO_overflow,
  output logic              FIFO_underflow
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wp_q, wp_d;
  logic [ADDR_W-1:0] rp_q, rp_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic push_acc;
  logic pop_acc;

  // Status comes only from the registered counter. Acceptance is therefore
  // decided by the occupancy at the start of the cycle. Because of this, an
  // empty FIFO never writes a byte through to the read side.
  assign FIFO_ctrl_empty = (cnt_q == '0);
  assign FIFO_ctrl_full  = (cnt_q == (ADDR_W+1)'(DEPTH));
  assign FIFO_level      = cnt_q;
  assign FIFO_rd_data    = rd_data_q;

  assign push_acc = host_wr_en && !FIFO_ctrl_full;
  assign pop_acc  = UART_ctrl_FIFO_r_en && !FIFO_ctrl_empty;

  always_comb begin
    wp_d      = wp_q;
    rp_d      = rp_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;
    if (push_acc) begin
      wp_d = ADDR_W'(wp_q + 1'b1);
    end
    if (pop_acc) begin
      rp_d      = ADDR_W'(rp_q + 1'b1);
      rd_data_d = mem_q[rp_q];
    end
    // A simultaneous accepted push and pop leaves the occupancy unchanged.
    if (push_acc && !pop_acc) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop_acc && !push_acc) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge glb_clk) begin
    if (glb_rst) begin
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage is not reset. Its contents are only visible through accepted
  // pops, and a pop can only read slots that have been written since reset.
  always_ff @(posedge glb_clk) begin
    if (push_acc && !glb_rst) begin
      mem_q[wp_q] <= host_wr_data;
    end
  end

`ifdef UART_FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // When a new violation and a clear occur in the same cycle, the violation
  // wins. The overflow term uses the raw full status, so a push that is
  // rejected while a pop drains a full FIFO still counts as an overflow.
  always_comb begin
    ovf_d = (ovf_q && !host_err_clr) || (host_wr_en && FIFO_ctrl_full);
    udf_d = (udf_q && !host_err_clr) || (UART_ctrl_FIFO_r_en && FIFO_ctrl_empty);
  end

  always_ff @(posedge glb_clk) begin
    if (glb_rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign FIFO_overflow  = ovf_q;
  assign FIFO_underflow = udf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = host_err_clr;
  assign FIFO_overflow  = 1'b0;
  assign FIFO_underflow = 1'b0;
`endif

endmodule
